// File: rtl/uart_packet_parser_pkg.sv
// Shared definitions for the UART packet parser: parser states and default framing parameters.
package uart_packet_parser_pkg;

    localparam logic [7:0] SOF_DEFAULT     = 8'hA5;
    localparam int         MAX_LEN_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } parserState_t;

endpackage

// File: rtl/uart_packet_parser_pkt_buffer.sv
// Payload store: DEPTH x 8 register array, one write port, combinational read port, no reset.
module pkt_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [7:0]    wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [7:0]    rdData
);

    logic [7:0] mem [DEPTH];

    // Write one payload byte per strobe; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // Combinational read so the first byte is on out_data in the cycle DRAIN is entered.
    assign rdData = mem[rdAddr];

endmodule

// File: rtl/uart_packet_parser.sv
// Framed-packet parser: SOF, LEN, payload, XOR checksum; buffers a frame and replays it
// on a valid/ready stream only once the checksum has matched.
module uart_packet_parser
    import uart_packet_parser_pkg::*;
#(
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_ready,
    input  logic       rx_endofpacket,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic [7:0] err_count,
    output logic       busy
);

    // One extra bit so an index can hold the value MAX_LEN itself.
    localparam int IW = $clog2(MAX_LEN) + 1;
    localparam int AW = $clog2(MAX_LEN);

    parserState_t   state, stNext;
    logic [IW-1:0]  lenReg, wrIdx, rdIdx;
    logic [7:0]     xorReg, rdData, errCount;
    logic           frameOk;
    logic           wrEn, errInc, okNext, lenOk, lastByte, handshake;

    assign lenOk     = (rx_data != 8'h00) && (rx_data <= 8'(MAX_LEN));
    assign lastByte  = (rdIdx == lenReg - IW'(1));
    assign handshake = (state == ST_DRAIN) && out_ready;

    assign out_valid = (state == ST_DRAIN);
    assign out_data  = (state == ST_DRAIN) ? rdData : 8'h00;
    assign out_last  = (state == ST_DRAIN) && lastByte;
    assign frame_ok  = frameOk;
    assign err_count = errCount;
    assign busy      = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= stNext;
    end

    // Next state: the byte is processed first, then a line-idle abort hits any half-parsed frame.
    always_comb begin
        stNext = state;
        wrEn   = 1'b0;
        errInc = 1'b0;
        okNext = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_data_ready && rx_data == SOF) stNext = ST_LEN;
            end
            ST_LEN: begin
                if (rx_data_ready) begin
                    if (lenOk) stNext = ST_PAYLOAD;
                    else begin
                        stNext = ST_IDLE;
                        errInc = 1'b1;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (rx_data_ready) begin
                    wrEn = 1'b1;
                    if (wrIdx + IW'(1) == lenReg) stNext = ST_CHK;
                end
            end
            ST_CHK: begin
                if (rx_data_ready) begin
                    if (rx_data == xorReg) begin
                        stNext = ST_DRAIN;
                        okNext = 1'b1;
                    end else begin
                        stNext = ST_IDLE;
                        errInc = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Bytes arriving while the previous frame is still draining are lost.
                if (rx_data_ready) errInc = 1'b1;
                if (handshake && lastByte) stNext = ST_IDLE;
            end
            default: stNext = ST_IDLE;
        endcase
        if (rx_endofpacket &&
            (stNext == ST_LEN || stNext == ST_PAYLOAD || stNext == ST_CHK)) begin
            stNext = ST_IDLE;
            errInc = 1'b1;
        end
    end

    // Datapath: length, running checksum, write/read indices, error counter, frame_ok pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lenReg   <= '0;
            xorReg   <= 8'h00;
            wrIdx    <= '0;
            rdIdx    <= '0;
            errCount <= 8'h00;
            frameOk  <= 1'b0;
        end else begin
            frameOk <= okNext;
            if (errInc && errCount != 8'hFF) errCount <= errCount + 8'd1;
            if (state == ST_LEN && rx_data_ready && lenOk) begin
                lenReg <= rx_data[IW-1:0];
                xorReg <= rx_data;
                wrIdx  <= '0;
            end
            if (wrEn) begin
                xorReg <= xorReg ^ rx_data;
                wrIdx  <= wrIdx + IW'(1);
            end
            // DRAIN is only entered from CHK, so rewinding there starts every replay at byte 0.
            if (state == ST_CHK)  rdIdx <= '0;
            else if (handshake)   rdIdx <= rdIdx + IW'(1);
        end
    end

    pkt_buffer #(.DEPTH(MAX_LEN)) uBuf (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wrIdx[AW-1:0]),
        .wrData (rx_data),
        .rdAddr (rdIdx[AW-1:0]),
        .rdData (rdData)
    );

endmodule

// File: tb/tb_uart_packet_parser.sv
// Directed bench for uart_packet_parser: a frame-level model predicts the output stream,
// error count and frame_ok pulses; a negedge monitor checks every output beat against it.
module tb_uart_packet_parser;
    import uart_packet_parser_pkg::*;

    typedef logic [7:0] u8;
    typedef u8 byteQ_t[$];
    typedef struct { u8 d; logic last; } outBeat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_ready, rx_endofpacket, out_ready;
    logic [7:0] out_data, err_count;
    logic       out_valid, out_last, frame_ok, busy;

    int checks = 0, errors = 0;
    int expErr = 0, expOk = 0, okSeen = 0;
    outBeat_t expQ[$];

    uart_packet_parser dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
        .rx_endofpacket(rx_endofpacket), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .frame_ok(frame_ok),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkInt(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bumpErr();
        if (expErr < 255) expErr++;
    endtask

    // Builds SOF, LEN, payload, XOR(LEN, payload).
    function automatic byteQ_t buildFrame(byteQ_t p);
        byteQ_t f;
        u8 x;
        x = u8'(p.size());
        f.push_back(SOF_DEFAULT);
        f.push_back(x);
        foreach (p[i]) begin
            f.push_back(p[i]);
            x ^= p[i];
        end
        f.push_back(x);
        return f;
    endfunction

    // A frame is accepted only if it is complete, has a legal length and a matching checksum.
    function automatic bit frameGood(byteQ_t f);
        int len;
        u8 x;
        if (f.size() < 3 || f[0] != SOF_DEFAULT) return 1'b0;
        len = int'(f[1]);
        if (len < 1 || len > MAX_LEN_DEFAULT || f.size() != len + 3) return 1'b0;
        x = f[1];
        for (int i = 0; i < len; i++) x ^= f[2 + i];
        return x == f[len + 2];
    endfunction

    // Called at posedge+1; presents one byte for one clock.
    task automatic sendByte(u8 b);
        rx_data = b;
        rx_data_ready = 1'b1;
        @(posedge clk); #1;
        rx_data_ready = 1'b0;
    endtask

    task automatic sendFrame(byteQ_t f);
        int len;
        foreach (f[i]) sendByte(f[i]);
        if (frameGood(f)) begin
            len = int'(f[1]);
            for (int i = 0; i < len; i++) expQ.push_back('{d: f[2 + i], last: (i == len - 1)});
            expOk++;
        end else begin
            bumpErr();
        end
    endtask

    task automatic pulseEop();
        rx_endofpacket = 1'b1;
        @(posedge clk); #1;
        rx_endofpacket = 1'b0;
    endtask

    task automatic waitIdle(int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check1("waitIdle", busy, 1'b0);
    endtask

    // Asserts reset mid-cycle and checks that the outputs clear without waiting for a clock.
    task automatic doReset();
        rst = 1'b1;
        #1;
        check1("rst out_valid", out_valid, 1'b0);
        check1("rst out_last", out_last, 1'b0);
        check1("rst frame_ok", frame_ok, 1'b0);
        check1("rst busy", busy, 1'b0);
        check8("rst out_data", out_data, 8'h00);
        check8("rst err_count", err_count, 8'h00);
        expQ.delete();
        expErr = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: every presented beat must be the next expected one and must hold until taken.
    logic heldV = 1'b0, prevValid = 1'b0, hLast;
    u8    hData;
    always @(negedge clk) begin
        if (rst) begin
            heldV = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (heldV) begin
                check1("hold valid", out_valid, 1'b1);
                check8("hold data", out_data, hData);
                check1("hold last", out_last, hLast);
            end
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected beat: got %h expected none", out_data);
                end else begin
                    check8("beat data", out_data, expQ[0].d);
                    check1("beat last", out_last, expQ[0].last);
                    if (out_ready) void'(expQ.pop_front());
                end
            end
            if (frame_ok) begin
                okSeen++;
                check1("frame_ok with first beat", out_valid && !prevValid, 1'b1);
            end
            heldV = out_valid && !out_ready;
            hData = out_data;
            hLast = out_last;
            prevValid = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        byteQ_t q, p;
        rst = 1'b1;
        rx_data = 8'h00;
        rx_data_ready = 1'b0;
        rx_endofpacket = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        doReset();

        // Good 3-byte frame; 03^11^22^33 = 03.
        q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        sendFrame(q);
        check1("s1 frame_ok latency", frame_ok, 1'b1);
        check1("s1 out_valid latency", out_valid, 1'b1);
        check8("s1 first byte", out_data, 8'h11);
        check1("s1 first not last", out_last, 1'b0);
        waitIdle(20);
        check8("s1 err_count", err_count, 8'h00);

        // Same frame, wrong checksum.
        doReset();
        q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        sendFrame(q);
        @(posedge clk); #1;
        check1("s2 out_valid", out_valid, 1'b0);
        check1("s2 busy", busy, 1'b0);
        check8("s2 err_count", err_count, 8'h01);

        // Truncated frame, then a 1-byte frame.
        doReset();
        sendByte(8'hA5); sendByte(8'h02); sendByte(8'h44);
        pulseEop();
        bumpErr();
        check1("s3 busy after eop", busy, 1'b0);
        check8("s3 err_count", err_count, 8'h01);
        q = {8'hA5, 8'h01, 8'h7E, 8'h7F};
        sendFrame(q);
        check8("s3 data", out_data, 8'h7E);
        check1("s3 last", out_last, 1'b1);
        waitIdle(20);

        // Illegal lengths 0 and MAX_LEN+1.
        doReset();
        q = {8'hA5, 8'h00}; sendFrame(q);
        q = {8'hA5, 8'h11}; sendFrame(q);
        @(posedge clk); #1;
        check8("s4 err_count", err_count, 8'h02);
        check1("s4 busy", busy, 1'b0);

        // Throttled drain with bytes arriving during it.
        doReset();
        p = {8'h10, 8'h20, 8'h30, 8'h40};
        sendFrame(buildFrame(p));
        fork
            begin
                sendByte(8'h55); sendByte(8'hA5); sendByte(8'h66);
                bumpErr(); bumpErr(); bumpErr();
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    out_ready = (i % 2 == 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        waitIdle(20);
        check8("s5 err_count", err_count, 8'h03);
        p = {8'h5A};
        sendFrame(buildFrame(p));
        waitIdle(20);
        check8("s5 err after next", err_count, 8'h03);

        // Reset mid-payload and mid-drain.
        doReset();
        q = {8'hA5, 8'h00}; sendFrame(q);
        check8("s6 err before rst", err_count, 8'h01);
        sendByte(8'hA5); sendByte(8'h04); sendByte(8'h01); sendByte(8'h02);
        check1("s6 busy in payload", busy, 1'b1);
        doReset();
        out_ready = 1'b0;
        p = {8'hC1, 8'hC2};
        sendFrame(buildFrame(p));
        @(posedge clk); #1;
        check1("s6 draining", out_valid, 1'b1);
        doReset();
        out_ready = 1'b1;
        p = {8'hDE, 8'hAD};
        sendFrame(buildFrame(p));
        waitIdle(20);

        // Longest legal frame.
        p = {};
        for (int i = 0; i < MAX_LEN_DEFAULT; i++) p.push_back(u8'(i * 7 + 1));
        sendFrame(buildFrame(p));
        check8("s7 first byte", out_data, 8'h01);
        waitIdle(40);
        check8("s7 err_count", err_count, 8'h00);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            q = {8'hA5, 8'h00};
            sendFrame(q);
        end
        check8("s8 saturated", err_count, 8'hFF);
        checkInt("s8 model err", int'(err_count), expErr);

        @(posedge clk); #1;
        checkInt("frame_ok count", okSeen, expOk);
        checkInt("beats drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
